// File: rtl/count_reader.sv
// Read controller for a bank of per-channel change counters: requests one counter,
// captures its response and presents it on a valid/ready port. Optional scan mode: COUNT_READER_SCAN_EN.
module count_reader #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int CH_W      = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CH_W-1:0]             sel,
`ifdef COUNT_READER_SCAN_EN
    input  logic                        scan,
    output logic                        scan_done,
`endif
    output logic                        busy,
    output logic                        req,
    output logic [NUM_CH-1:0]           idx,
    input  logic [NUM_CH-1:0]           valid_cont,
    input  logic [NUM_CH*CNT_WIDTH-1:0] data_cont,
    output logic                        out_valid,
    output logic [CNT_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]             out_ch,
    input  logic                        out_ready,
    output logic                        err_timeout,
    output logic                        err_sel
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                 state_reg, state_next;
    logic [CH_W-1:0]        ch_reg, ch_next;
    logic [7:0]             tmo_reg, tmo_next;
    logic                   busy_reg, busy_next;
    logic                   req_reg, req_next;
    logic [NUM_CH-1:0]      idx_reg, idx_next;
    logic                   out_valid_reg, out_valid_next;
    logic [CNT_WIDTH-1:0]   out_data_reg, out_data_next;
    logic [CH_W-1:0]        out_ch_reg, out_ch_next;
    logic                   err_timeout_reg, err_timeout_next;
    logic                   err_sel_reg, err_sel_next;
`ifdef COUNT_READER_SCAN_EN
    logic                   scan_active_reg, scan_active_next;
    logic                   scan_done_reg, scan_done_next;
`endif

    logic [31:0]            sel_ext;
    logic                   sel_ok;
    logic                   read_done;

    // Mux the selected channel's valid/data through an OR chain of one-hot hits.
    logic [NUM_CH:0]        valid_chain;
    logic [CNT_WIDTH-1:0]   data_chain [NUM_CH+1];

    assign valid_chain[0] = 1'b0;
    assign data_chain[0]  = '0;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mux
            logic hit;
            assign hit              = (ch_reg == CH_W'(gi));
            assign valid_chain[gi+1] = valid_chain[gi] | (hit & valid_cont[gi]);
            assign data_chain[gi+1]  = data_chain[gi] |
                                       (hit ? data_cont[gi*CNT_WIDTH +: CNT_WIDTH] : '0);
        end
    endgenerate

    assign sel_ext = 32'(sel);
    assign sel_ok  = (sel_ext < 32'(NUM_CH));

    always_comb begin
        state_next       = state_reg;
        ch_next          = ch_reg;
        tmo_next         = tmo_reg;
        req_next         = req_reg;
        idx_next         = idx_reg;
        out_valid_next   = out_valid_reg;
        out_data_next    = out_data_reg;
        out_ch_next      = out_ch_reg;
        err_timeout_next = 1'b0;
        err_sel_next     = 1'b0;
        read_done        = 1'b0;
`ifdef COUNT_READER_SCAN_EN
        scan_active_next = scan_active_reg;
        scan_done_next   = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
`ifdef COUNT_READER_SCAN_EN
                if (scan) begin
                    ch_next          = '0;
                    scan_active_next = 1'b1;
                    req_next         = 1'b1;
                    idx_next         = NUM_CH'(1);
                    state_next       = REQ;
                end else
`endif
                if (start) begin
                    if (sel_ok) begin
                        ch_next    = sel;
                        req_next   = 1'b1;
                        idx_next   = NUM_CH'(1) << sel;
                        state_next = REQ;
                    end else begin
                        err_sel_next = 1'b1;
                    end
                end
            end
            REQ: begin
                // A valid flag seen here may be left over from a previous read.
                req_next   = 1'b0;
                idx_next   = '0;
                tmo_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (valid_chain[NUM_CH]) begin
                    out_data_next  = data_chain[NUM_CH];
                    out_ch_next    = ch_reg;
                    out_valid_next = 1'b1;
                    state_next     = HOLD;
                end else if (tmo_reg == 8'(TIMEOUT - 1)) begin
                    err_timeout_next = 1'b1;
                    read_done        = 1'b1;
                end else begin
                    tmo_next = tmo_reg + 8'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    read_done      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (read_done) begin
            state_next = IDLE;
`ifdef COUNT_READER_SCAN_EN
            if (scan_active_reg) begin
                if (ch_reg == CH_W'(NUM_CH - 1)) begin
                    scan_active_next = 1'b0;
                    scan_done_next   = 1'b1;
                end else begin
                    ch_next    = ch_reg + CH_W'(1);
                    req_next   = 1'b1;
                    idx_next   = NUM_CH'(1) << (ch_reg + CH_W'(1));
                    state_next = REQ;
                end
            end
`endif
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            ch_reg          <= '0;
            tmo_reg         <= '0;
            busy_reg        <= 1'b0;
            req_reg         <= 1'b0;
            idx_reg         <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_ch_reg      <= '0;
            err_timeout_reg <= 1'b0;
            err_sel_reg     <= 1'b0;
`ifdef COUNT_READER_SCAN_EN
            scan_active_reg <= 1'b0;
            scan_done_reg   <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            ch_reg          <= ch_next;
            tmo_reg         <= tmo_next;
            busy_reg        <= busy_next;
            req_reg         <= req_next;
            idx_reg         <= idx_next;
            out_valid_reg   <= out_valid_next;
            out_data_reg    <= out_data_next;
            out_ch_reg      <= out_ch_next;
            err_timeout_reg <= err_timeout_next;
            err_sel_reg     <= err_sel_next;
`ifdef COUNT_READER_SCAN_EN
            scan_active_reg <= scan_active_next;
            scan_done_reg   <= scan_done_next;
`endif
        end
    end

    assign busy        = busy_reg;
    assign req         = req_reg;
    assign idx         = idx_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_ch      = out_ch_reg;
    assign err_timeout = err_timeout_reg;
    assign err_sel     = err_sel_reg;
`ifdef COUNT_READER_SCAN_EN
    assign scan_done   = scan_done_reg;
`endif

endmodule

// File: tb/tb_count_reader.sv
// Self-checking bench for count_reader: vector table, random reads against a
// cycle-timeline model of each read, and a reset-during-WAIT sequence.
module tb_count_reader;

    localparam int NUM_CH    = 4;
    localparam int CNT_WIDTH = 8;
    localparam int CH_W      = 3;
    localparam int TIMEOUT   = 15;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        start;
    logic [CH_W-1:0]             sel;
    logic                        busy;
    logic                        req;
    logic [NUM_CH-1:0]           idx;
    logic [NUM_CH-1:0]           valid_cont;
    logic [NUM_CH*CNT_WIDTH-1:0] data_cont;
    logic                        out_valid;
    logic [CNT_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]             out_ch;
    logic                        out_ready;
    logic                        err_timeout;
    logic                        err_sel;

    logic                        bank_valid [NUM_CH];
    logic [CNT_WIDTH-1:0]        bank_data  [NUM_CH];

    assign valid_cont = {bank_valid[3], bank_valid[2], bank_valid[1], bank_valid[0]};
    assign data_cont  = {bank_data[3], bank_data[2], bank_data[1], bank_data[0]};

    count_reader #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel),
        .busy(busy), .req(req), .idx(idx),
        .valid_cont(valid_cont), .data_cont(data_cont),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .err_timeout(err_timeout), .err_sel(err_sel)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [CNT_WIDTH-1:0] m_data;
    logic [CH_W-1:0]      m_ch;

    typedef struct {
        int                   s;
        int                   d;      // WAIT edges before the counter answers
        logic [CNT_WIDTH-1:0] val;
        int                   r;      // HOLD cycles with out_ready low
        bit                   stale;  // selected valid already high during REQ
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input bit eb, input bit er, input logic [NUM_CH-1:0] ei,
                              input bit ev, input bit et, input bit es);
        chk("busy", 32'(busy), 32'(eb));
        chk("req", 32'(req), 32'(er));
        chk("idx", 32'(idx), 32'(ei));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("err_timeout", 32'(err_timeout), 32'(et));
        chk("err_sel", 32'(err_sel), 32'(es));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_ch", 32'(out_ch), 32'(m_ch));
    endtask

    task automatic noise_bank();
        for (int i = 0; i < NUM_CH; i++) begin
            bank_valid[i] = 1'($urandom);
            bank_data[i]  = 8'($urandom);
        end
    endtask

    // Interval j = time after the j-th edge following the edge that samples start.
    task automatic run_txn(input int s, input int d, input logic [CNT_WIDTH-1:0] val,
                           input int r, input bit stale);
        bit       bad;
        bit       tmo;
        bit       ok;
        bit       ev;
        int       last_j;
        logic [1:0] sc;
        bad    = (s >= NUM_CH);
        tmo    = !bad && (d >= TIMEOUT);
        ok     = !bad && !tmo;
        last_j = bad ? 1 : (tmo ? TIMEOUT + 1 : 3 + d + r);
        sc     = 2'(s);
        noise_bank();
        if (!bad) begin
            bank_valid[sc] = stale;
            bank_data[sc]  = ~val;
        end
        start     = 1'b1;
        sel       = 3'(s);
        out_ready = 1'($urandom);
        for (int j = 0; j <= last_j; j++) begin
            @(posedge clk);
            #1;
            if (ok && j == 2 + d) begin
                m_data = val;
                m_ch   = 3'(s);
            end
            ev = ok && (j >= 2 + d) && (j <= 2 + d + r);
            check_outs(!bad && j < last_j, !bad && j == 0,
                       (!bad && j == 0) ? (4'(1) << s) : 4'(0),
                       ev, tmo && j == last_j, bad && j == 0);
            noise_bank();
            if (!bad) begin
                bank_valid[sc] = (j == 0) ? stale : (j == 1 + d);
                bank_data[sc]  = (j == 1 + d) ? val : ~val;
            end
            if (!bad && j < last_j) begin
                start = 1'($urandom);
                sel   = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            if (ok && j >= 2 + d + r)  out_ready = 1'b1;
            else if (ok && j >= 2 + d) out_ready = 1'b0;
            else                       out_ready = 1'($urandom);
        end
        $display("[TB] read sel=%0d delay=%0d val=%02h ready_wait=%0d stale=%0d -> %s",
                 s, d, val, r, stale, bad ? "err_sel" : (tmo ? "timeout" : "data"));
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{s: 2, d: 0,  val: 8'h05, r: 0, stale: 1'b0};
        vecs[1] = '{s: 1, d: 0,  val: 8'h0A, r: 0, stale: 1'b1};
        vecs[2] = '{s: 0, d: 1,  val: 8'h3C, r: 5, stale: 1'b0};
        vecs[3] = '{s: 3, d: 40, val: 8'h77, r: 0, stale: 1'b0};
        vecs[4] = '{s: 5, d: 0,  val: 8'h11, r: 0, stale: 1'b0};
        vecs[5] = '{s: 2, d: 14, val: 8'hA5, r: 1, stale: 1'b0};
        vecs[6] = '{s: 3, d: 15, val: 8'h5A, r: 0, stale: 1'b0};
        vecs[7] = '{s: 1, d: 0,  val: 8'hFF, r: 0, stale: 1'b1};
        vecs[8] = '{s: 7, d: 0,  val: 8'h22, r: 0, stale: 1'b0};
        vecs[9] = '{s: 3, d: 2,  val: 8'h81, r: 2, stale: 1'b1};

        reset     = 1'b1;
        start     = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        m_data    = '0;
        m_ch      = '0;
        noise_bank();
        repeat (3) @(posedge clk);
        #1;
        check_outs(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        $display("[TB] reset released");

        foreach (vecs[k])
            run_txn(vecs[k].s, vecs[k].d, vecs[k].val, vecs[k].r, vecs[k].stale);

        for (int n = 0; n < 40; n++) begin
            int rd;
            rd = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 6));
            run_txn(int'($urandom_range(0, 7)), rd, 8'($urandom),
                    int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Reset while WAITing: the pending response must never surface.
        start = 1'b1;
        sel   = 3'd1;
        noise_bank();
        bank_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_in_wait", 32'(busy), 32'd1);
        reset         = 1'b1;
        bank_valid[1] = 1'b1;
        bank_data[1]  = 8'hC3;
        @(posedge clk);
        #1;
        m_data = '0;
        m_ch   = '0;
        check_outs(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset     = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check_outs(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        $display("[TB] reset during WAIT sequence done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/count_reader.md
Name: count_reader

Overview:
- Downstream read controller for a bank of per-channel change counters.
- On command, it drives `req` and a one-hot `idx` to the selected counter and captures that counter's `valid_cont`/`data_cont` response.
- It presents the captured value on a valid/ready output port tagged with the channel number.
- It sits between the counter bank and the result/report logic, and guards against a non-responding counter with a timeout.

Parameters:
- NUM_CH, 4, number of counter channels attached (2..16).
- CNT_WIDTH, 8, width of each counter's `data_cont`.
- CH_W, 2, width of the channel select; must satisfy 2^CH_W >= NUM_CH.
- TIMEOUT, 15, number of WAIT cycles without a response before aborting (1..255).

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  read command, sampled in IDLE only.
- sel  input  CH_W  channel to read, sampled with `start`.
- busy  output  1  high in every state except IDLE.
- req  output  1  read request to the counter bank.
- idx  output  NUM_CH  one-hot channel enable; bit i goes to counter i.
- valid_cont  input  NUM_CH  per-channel valid flags from the counters.
- data_cont  input  NUM_CH*CNT_WIDTH  concatenated counts; channel i occupies [i*CNT_WIDTH +: CNT_WIDTH].
- out_valid  output  1  captured result available.
- out_data  output  CNT_WIDTH  captured count.
- out_ch  output  CH_W  channel the count belongs to.
- out_ready  input  1  consumer accepts the result.
- err_timeout  output  1  one-cycle pulse when a read aborts.
- err_sel  output  1  one-cycle pulse when `start` is given with `sel` >= NUM_CH.

Behaviour:
- Reset values (every output): busy=0, req=0, idx=0, out_valid=0, out_data=0, out_ch=0, err_timeout=0, err_sel=0. State=IDLE, timeout counter=0.
- Reset applies in any state. A read in flight is discarded and no result is presented.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - `start`=1 and `sel` < NUM_CH: latch `sel` into the channel register, drive req=1 and idx=(1<<sel), go to REQ.
  - `start`=1 and `sel` >= NUM_CH: err_sel=1 for one cycle, stay in IDLE.
- REQ (exactly one cycle):
  - `valid_cont` is ignored in this cycle; a flag still high from an earlier read is stale.
  - Next state WAIT, with req=0, idx=0 and the timeout counter cleared.
- WAIT:
  - On the edge where valid_cont[ch]=1: out_data <= data_cont slice for `ch`, out_ch <= ch, out_valid <= 1, go to HOLD.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT-1 without a response: err_timeout=1 for one cycle, go to IDLE, out_valid stays 0.
- HOLD:
  - out_valid=1 with out_data and out_ch held stable until a cycle in which out_ready=1.
  - On the edge ending that cycle: out_valid <= 0, go to IDLE.
  - out_ready may already be high when out_valid rises; the transfer then completes in that first HOLD cycle.
- Latency: edge sampling `start` -> req high for one cycle -> counter responds on the next edge -> out_valid high 2 clocks after `start` was sampled.
- `start` while busy=1 is ignored. It is not queued.
- Data capture uses only the selected channel's slice. Other channels' valid/data are don't-care.
- out_data and out_ch keep their last captured values after the handshake completes (not cleared in IDLE).
- A new `start` may be accepted in the cycle right after a HOLD handshake. Back-to-back throughput is one result per 4 cycles with out_ready tied high.

Optional Feature:
- Macro: COUNT_READER_SCAN_EN.
- When defined:
  - Adds input `scan`, sampled in IDLE with priority over `start`.
  - A scan reads channels 0..NUM_CH-1 in order, each using REQ/WAIT/HOLD exactly as above.
  - After each HOLD handshake the FSM advances to REQ for the next channel instead of IDLE.
  - After channel NUM_CH-1 it returns to IDLE.
  - A timeout on any channel pulses err_timeout, skips that channel and continues with the next.
  - Adds output `scan_done`, a one-cycle pulse when the scan returns to IDLE.
- When not defined: the `scan` and `scan_done` ports do not exist, and behaviour is exactly as described above.

Test Plan:
- Reset, then start=1 sel=2 with counter 2 holding 0x05 and out_ready=1 -> req=1 with idx=4'b0100 for exactly 1 cycle; out_valid=1, out_data=0x05, out_ch=2 two clocks after start; busy back to 0 the next cycle.
- Channel 1 valid_cont stuck high from an earlier read; start sel=1 with the counter responding 0x0A -> the value captured in WAIT is 0x0A (the REQ-cycle stale valid is ignored).
- out_ready=0 for 5 cycles after out_valid -> out_valid, out_data and out_ch stable for all 6 cycles; single transfer on out_ready=1; a start during HOLD is ignored.
- valid_cont[3] held 0 after start sel=3, TIMEOUT=15 -> err_timeout pulses 15 cycles after entering WAIT; out_valid never asserts; FSM returns to IDLE.
- start sel=5 with NUM_CH=4 (CH_W=3) -> err_sel pulses one cycle; req stays 0; busy stays 0.
- reset asserted while in WAIT -> next cycle all outputs equal their reset values; no out_valid ever appears for the aborted read.
